// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset CPU: opcode and funct
// encodings, the ALU operation set and well-known register indices.
package cpu_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instruction bits [5:0]
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

endpackage

// File: rtl/reg_file.sv
// 32-entry general-purpose register file, two combinational read ports and
// one write port committed at the rising clock edge. Register $0 always
// reads zero and ignores writes. Synchronous active-high reset clears all.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rs_addr / rs_data   read port A
//   rt_addr / rt_data   read port B
//   we, wr_addr, wr_data  write port
module reg_file
  import cpu_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rs_addr,
  input  logic [4:0]          rt_addr,
  output logic [bit_size-1:0] rs_data,
  output logic [bit_size-1:0] rt_data,
  input  logic                we,
  input  logic [4:0]          wr_addr,
  input  logic [bit_size-1:0] wr_data
);

  logic [bit_size-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads return the pre-edge contents, so an instruction reading its own
  // destination sees the old value.
  assign rs_data = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];

endmodule

// File: rtl/single_cycle_cpu_top.sv
// Single-cycle 32-bit MIPS-subset CPU core. Each instruction is fetched,
// decoded, executed and retired in one clock; memories are external.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   IM_Address      PC as word index into instruction memory
//   Instruction     instruction word at IM_Address (same cycle)
//   DM_Address      data word index = (rs + sext(imm16)) truncated
//   DM_enable       store strobe, write happens at the next rising edge
//   DM_Write_Data   rt register value (store data)
//   DM_Read_Data    data word at DM_Address (same cycle, used by lw)
module single_cycle_cpu_top
  import cpu_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [mem_size-1:0] IM_Address,
  input  logic [bit_size-1:0] Instruction,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data
);

  function automatic logic [bit_size-1:0] alu(
    input alu_op_e                    op,
    input logic signed [bit_size-1:0] a,
    input logic signed [bit_size-1:0] b,
    input logic        [4:0]          sh
  );
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {{(bit_size-1){1'b0}}, (a < b)};
      ALU_SLL: return $unsigned(b) << sh;
      ALU_SRL: return $unsigned(b) >> sh;
      default: return '0;
    endcase
  endfunction

  logic [mem_size-1:0] pc;
  logic [mem_size-1:0] pc_plus1;
  logic [mem_size-1:0] next_pc;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  logic [bit_size-1:0] sext_imm, zext_imm;
  logic [bit_size-1:0] rs_data, rt_data;
  logic [bit_size-1:0] alu_b, alu_y, wr_data;
  logic [4:0]          wr_addr;
  logic                reg_we, wr_mem, wr_link, dm_we;
  alu_op_e             alu_op;

  assign op     = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign shamt  = Instruction[10:6];
  assign funct  = Instruction[5:0];
  assign imm    = Instruction[15:0];
  assign target = Instruction[25:0];

  assign sext_imm = {{(bit_size-16){imm[15]}}, imm};
  assign zext_imm = {{(bit_size-16){1'b0}}, imm};
  assign pc_plus1 = pc + mem_size'(1);

  reg_file #(.bit_size(bit_size)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .we      (reg_we && !rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Decode: anything unrecognised falls through to the defaults, i.e. a NOP.
  always_comb begin
    reg_we  = 1'b0;
    wr_addr = rt;
    wr_mem  = 1'b0;
    wr_link = 1'b0;
    dm_we   = 1'b0;
    alu_op  = ALU_ADD;
    alu_b   = sext_imm;
    next_pc = pc_plus1;
    case (op)
      OP_RTYPE: begin
        wr_addr = rd;
        alu_b   = rt_data;
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; reg_we = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; reg_we = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; reg_we = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  reg_we = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; reg_we = 1'b1; end
          FN_SLL: begin alu_op = ALU_SLL; reg_we = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; reg_we = 1'b1; end
          FN_JR:  next_pc = mem_size'(rs_data);
          default: ;
        endcase
      end
      OP_ADDI: reg_we = 1'b1;
      OP_SLTI: begin alu_op = ALU_SLT; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; alu_b = zext_imm; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = zext_imm; reg_we = 1'b1; end
      OP_LW:   begin reg_we = 1'b1; wr_mem = 1'b1; end
      OP_SW:   dm_we = 1'b1;
      OP_BEQ:  if (rs_data == rt_data) next_pc = pc_plus1 + mem_size'(sext_imm);
      OP_BNE:  if (rs_data != rt_data) next_pc = pc_plus1 + mem_size'(sext_imm);
      OP_J:    next_pc = mem_size'(target);
      OP_JAL: begin
        next_pc = mem_size'(target);
        reg_we  = 1'b1;
        wr_link = 1'b1;
        wr_addr = REG_RA;
      end
      default: ;
    endcase
  end

  assign alu_y   = alu(alu_op, rs_data, alu_b, shamt);
  assign wr_data = wr_link ? bit_size'(pc_plus1) :
                   wr_mem  ? DM_Read_Data : alu_y;

  assign IM_Address    = pc;
  assign DM_Address    = mem_size'(rs_data + sext_imm);
  assign DM_Write_Data = rt_data;
  assign DM_enable     = dm_we && !rst;

  // Retire: PC update at the clock edge
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_single_cycle_cpu_top.sv
module tb_single_cycle_cpu_top;

  logic        clk;
  logic        rst;
  logic [15:0] IM_Address;
  logic [31:0] Instruction;
  logic [15:0] DM_Address;
  logic        DM_enable;
  logic [31:0] DM_Write_Data;
  logic [31:0] DM_Read_Data;

  logic [31:0] imem [64];
  logic [31:0] dmem [64] = '{default: 32'h0};

  typedef struct {
    int          addr;
    logic [31:0] data;
  } st_t;
  st_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  single_cycle_cpu_top dut (
    .clk           (clk),
    .rst           (rst),
    .IM_Address    (IM_Address),
    .Instruction   (Instruction),
    .DM_Address    (DM_Address),
    .DM_enable     (DM_enable),
    .DM_Write_Data (DM_Write_Data),
    .DM_Read_Data  (DM_Read_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Instruction  = imem[6'(IM_Address)];
  assign DM_Read_Data = dmem[6'(DM_Address)];

  always @(posedge clk) begin
    if (DM_enable) dmem[6'(DM_Address)] <= DM_Write_Data;
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_st(input int addr, input logic [31:0] data);
    st_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // One instruction cycle: check PC and store strobe, pop a pending store if
  // one is issued, then advance to 2 time units after the next rising edge.
  task automatic step(input int exp_pc);
    logic exp_en;
    st_t  e;
    check($sformatf("im_address@%0d", exp_pc), 32'(IM_Address), 32'(exp_pc));
    exp_en = (imem[exp_pc][31:26] == 6'h2B) && !rst;
    check($sformatf("dm_enable@%0d", exp_pc), 32'(DM_enable), 32'(exp_en));
    if (DM_enable === 1'b1) begin
      check($sformatf("store_expected@%0d", exp_pc), 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("dm_address@%0d", exp_pc), 32'(DM_Address), 32'(e.addr));
        check($sformatf("dm_wdata@%0d", exp_pc), DM_Write_Data, e.data);
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = enc_i(8, 0, 1, 5);             // addi $1,$0,5
    imem[1]  = enc_i(8, 0, 2, -3);            // addi $2,$0,-3
    imem[2]  = enc_r(1, 2, 3, 0, 'h20);       // add  $3,$1,$2
    imem[3]  = enc_i('h2B, 0, 3, 0);          // sw   $3,0($0)
    imem[4]  = enc_r(1, 2, 3, 0, 'h22);       // sub  $3,$1,$2
    imem[5]  = enc_i('h2B, 0, 3, 1);
    imem[6]  = enc_r(2, 1, 3, 0, 'h2A);       // slt  $3,$2,$1
    imem[7]  = enc_i('h2B, 0, 3, 2);
    imem[8]  = enc_i(8, 0, 8, 'h3C);          // addi $8,$0,0x3C
    imem[9]  = enc_r(1, 8, 3, 0, 'h24);       // and  $3,$1,$8
    imem[10] = enc_i('h2B, 0, 3, 3);
    imem[11] = enc_r(1, 8, 3, 0, 'h25);       // or   $3,$1,$8
    imem[12] = enc_i('h2B, 0, 3, 4);
    imem[13] = enc_r(0, 1, 3, 4, 'h00);       // sll  $3,$1,4
    imem[14] = enc_i('h2B, 0, 3, 5);
    imem[15] = enc_r(0, 2, 3, 28, 'h02);      // srl  $3,$2,28
    imem[16] = enc_i('h2B, 0, 3, 6);
    imem[17] = enc_r(1, 2, 3, 0, 'h2A);       // slt  $3,$1,$2
    imem[18] = enc_i('h2B, 0, 3, 7);
    imem[19] = enc_i('h2B, 0, 1, 10);         // sw   $1,10($0)
    imem[20] = enc_i(4, 0, 0, 3);             // beq  $0,$0,+3
    for (int i = 21; i < 24; i++) imem[i] = enc_i('h2B, 0, 1, 40);
    imem[24] = enc_i(5, 0, 0, 3);             // bne  $0,$0,+3
    imem[25] = enc_i('h23, 0, 4, 10);         // lw   $4,10($0)
    imem[26] = enc_i('h2B, 0, 4, 11);         // sw   $4,11($0)
    imem[27] = enc_i(8, 0, 0, 7);             // addi $0,$0,7
    imem[28] = enc_i('h2B, 0, 0, 12);         // sw   $0,12($0)
    imem[29] = enc_i('h0A, 2, 3, -2);         // slti $3,$2,-2
    imem[30] = enc_i('h2B, 0, 3, 8);
    imem[31] = enc_i('h0C, 2, 3, 'hFFF0);     // andi $3,$2,0xFFF0
    imem[32] = enc_i('h2B, 0, 3, 9);
    imem[33] = enc_i('h0D, 1, 3, 'h8000);     // ori  $3,$1,0x8000
    imem[34] = enc_i('h2B, 0, 3, 13);
    imem[35] = enc_i(8, 0, 10, 20);           // addi $10,$0,20
    imem[36] = enc_i('h2B, 10, 1, -5);        // sw   $1,-5($10)
    imem[37] = enc_j(2, 44);                  // j    44
    for (int i = 38; i < 44; i++) imem[i] = enc_i('h2B, 0, 1, 40);
    imem[44] = enc_j(3, 51);                  // jal  51
    imem[45] = enc_j(2, 60);                  // j    60
    imem[51] = enc_i('h2B, 0, 31, 16);        // sw   $31,16($0)
    imem[52] = enc_r(31, 0, 0, 0, 'h08);      // jr   $31
    imem[60] = enc_i(4, 0, 0, -1);            // beq  $0,$0,-1 (halt)

    repeat (2) @(posedge clk);
    #2;
    check("rst_im_address", 32'(IM_Address), 32'd0);
    check("rst_dm_enable", 32'(DM_enable), 32'd0);
    rst = 1'b0;
    #1;

    push_st(0, 32'h2);
    push_st(1, 32'h8);
    push_st(2, 32'h1);
    push_st(3, 32'h4);
    push_st(4, 32'h3D);
    push_st(5, 32'h50);
    push_st(6, 32'hF);
    push_st(7, 32'h0);
    push_st(10, 32'h5);
    push_st(11, 32'h5);
    push_st(12, 32'h0);
    push_st(8, 32'h1);
    push_st(9, 32'h0000FFF0);
    push_st(13, 32'h00008005);
    push_st(15, 32'h5);
    push_st(16, 32'd45);

    for (int p = 0; p <= 20; p++) step(p);
    step(24);
    for (int p = 25; p <= 37; p++) step(p);
    step(44);
    step(51);
    step(52);
    step(45);
    repeat (3) step(60);

    // Reset arrives while a store is presented: it must not complete.
    imem[60] = enc_i('h2B, 0, 1, 30);         // sw $1,30($0)
    rst = 1'b1;
    #1;
    step(60);

    imem[0] = enc_i('h2B, 0, 1, 20);          // sw   $1,20($0)
    imem[1] = enc_i('h2B, 0, 31, 21);         // sw   $31,21($0)
    imem[2] = enc_i('h2B, 0, 8, 22);          // sw   $8,22($0)
    imem[3] = enc_i(8, 0, 5, 9);              // addi $5,$0,9
    imem[4] = enc_i('h2B, 0, 5, 23);          // sw   $5,23($0)
    imem[5] = enc_i(4, 0, 0, -1);             // beq  $0,$0,-1
    rst = 1'b0;
    #1;
    push_st(20, 32'h0);
    push_st(21, 32'h0);
    push_st(22, 32'h0);
    push_st(23, 32'h9);
    for (int p = 0; p <= 5; p++) step(p);
    step(5);

    check("dmem30_untouched", dmem[30], 32'h0);
    check("dmem11_lw_sw", dmem[11], 32'h5);
    check("dmem16_link", dmem[16], 32'd45);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
